sel_table: RTL and testbench

Selector counter table for the tournament branch predictor: it holds one 2-bit chooser state per index and answers "use global or local predictor" lookups. On branch resolution it reads the indexed state, sends it with a correctness flag to the downstream `fsm_for_sel` stage, and writes back that stage's registered next state. It also owns the pipeline bookkeeping, the same-index forwarding and the stall logic that keep back-to-back updates coherent.

---
 rtl/sel_table.sv | 109 ++++++++++
 tb/tb_sel_table.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sel_table.sv
// Tournament-predictor chooser table: 2-bit selector state per index, one-cycle
// lookups, and a two-stage update pipeline around the external fsm_for_sel stage.
module sel_table #(
  parameter  int IDX_W      = 10,
  localparam int DATA_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pre_valid,
  input  logic [IDX_W-1:0]      pre_idx,
  output logic                  pre_sel_valid,
  output logic                  pre_use_global,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [IDX_W-1:0]      upd_idx,
  input  logic                  upd_local_ok,
  input  logic                  upd_global_ok,
  output logic [DATA_WIDTH-1:0] fsm_in_data,
  output logic                  fsm_torf,
  input  logic [DATA_WIDTH-1:0] fsm_out_data,
  input  logic                  fsm_wr_en
);

  localparam logic [DATA_WIDTH-1:0] WELL_NTAKEN = 2'b00;
  localparam logic [DATA_WIDTH-1:0] NTAKEN      = 2'b01;
  localparam logic [DATA_WIDTH-1:0] TAKEN       = 2'b10;
  localparam logic [DATA_WIDTH-1:0] WELL_TAKEN  = 2'b11;
  localparam logic [DATA_WIDTH-1:0] INIT        = NTAKEN;
  localparam int                    DEPTH       = 1 << IDX_W;

  function automatic logic side_global(input logic [DATA_WIDTH-1:0] s);
    return (s == TAKEN) || (s == WELL_TAKEN);
  endfunction

  logic [DATA_WIDTH-1:0] tbl_q [DEPTH];

  logic                  pre_sel_valid_q, pre_sel_valid_d;
  logic                  pre_use_global_q, pre_use_global_d;
  logic                  s1_vld_q, s1_vld_d;
  logic                  s2_vld_q, s2_vld_d;
  logic [IDX_W-1:0]      s1_idx_q, s1_idx_d;
  logic [IDX_W-1:0]      s2_idx_q, s2_idx_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  s1_torf_q, s1_torf_d;
  logic                  tbl_wr_d;
  logic [DATA_WIDTH-1:0] pre_rd;
  logic [DATA_WIDTH-1:0] upd_rd;
  logic                  upd_accept;

  always_comb begin
    tbl_wr_d = s2_vld_q && fsm_wr_en;

    // Lookup is write-first against the S2 commit happening this cycle
    pre_rd = (tbl_wr_d && (s2_idx_q == pre_idx)) ? fsm_out_data : tbl_q[pre_idx];
    pre_sel_valid_d  = pre_valid;
    pre_use_global_d = pre_valid && side_global(pre_rd);

    upd_ready  = !reset && !(s1_vld_q && (s1_idx_q == upd_idx));
    upd_accept = upd_valid && upd_ready && (upd_local_ok != upd_global_ok);

    // S2 forwarding covers the not-yet-written result, including wr_en-low holds
    upd_rd    = (s2_vld_q && (s2_idx_q == upd_idx)) ? fsm_out_data : tbl_q[upd_idx];
    s1_vld_d  = upd_accept;
    s1_idx_d  = upd_idx;
    s1_data_d = upd_rd;
    s1_torf_d = side_global(upd_rd) ? upd_global_ok : upd_local_ok;

    s2_vld_d  = s1_vld_q;
    s2_idx_d  = s1_idx_q;

    fsm_in_data    = s1_vld_q ? s1_data_q : INIT;
    fsm_torf       = s1_vld_q && s1_torf_q;
    pre_sel_valid  = pre_sel_valid_q;
    pre_use_global = pre_use_global_q;
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_sel_valid_q  <= 1'b0;
      pre_use_global_q <= 1'b0;
      s1_vld_q         <= 1'b0;
      s2_vld_q         <= 1'b0;
    end else begin
      pre_sel_valid_q  <= pre_sel_valid_d;
      pre_use_global_q <= pre_use_global_d;
      s1_vld_q         <= s1_vld_d;
      s2_vld_q         <= s2_vld_d;
    end
  end

  // Pipeline data registers
  always_ff @(posedge clk) begin
    s1_idx_q  <= s1_idx_d;
    s1_data_q <= s1_data_d;
    s1_torf_q <= s1_torf_d;
    s2_idx_q  <= s2_idx_d;
  end

  // Table storage
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= INIT;
    end else if (tbl_wr_d) begin
      tbl_q[s2_idx_q] <= fsm_out_data;
    end
  end

endmodule

// File: tb/tb_sel_table.sv
// Directed bench for sel_table; the bench plays the registered fsm_for_sel stage.
module tb_sel_table;

  localparam int IDX_W = 10;
  localparam logic [1:0] WN   = 2'b00;
  localparam logic [1:0] NT   = 2'b01;
  localparam logic [1:0] TK   = 2'b10;
  localparam logic [1:0] WT   = 2'b11;
  localparam logic [1:0] INIT = NT;

  logic             clk = 1'b0;
  logic             reset;
  logic             pre_valid;
  logic [IDX_W-1:0] pre_idx;
  logic             pre_sel_valid;
  logic             pre_use_global;
  logic             upd_valid;
  logic             upd_ready;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_local_ok;
  logic             upd_global_ok;
  logic [1:0]       fsm_in_data;
  logic             fsm_torf;
  logic [1:0]       fsm_out_data = 2'b00;
  logic             fsm_wr_en = 1'b0;

  int vectors = 0;
  int errs    = 0;

  sel_table #(.IDX_W(IDX_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .pre_valid     (pre_valid),
    .pre_idx       (pre_idx),
    .pre_sel_valid (pre_sel_valid),
    .pre_use_global(pre_use_global),
    .upd_valid     (upd_valid),
    .upd_ready     (upd_ready),
    .upd_idx       (upd_idx),
    .upd_local_ok  (upd_local_ok),
    .upd_global_ok (upd_global_ok),
    .fsm_in_data   (fsm_in_data),
    .fsm_torf      (fsm_torf),
    .fsm_out_data  (fsm_out_data),
    .fsm_wr_en     (fsm_wr_en)
  );

  always #5 clk = ~clk;

  // Chooser FSM: a correct side strengthens, a wrong side steps toward the other side
  function automatic logic [1:0] fsm_next(input logic [1:0] s, input logic t);
    case (s)
      WN:      return t ? WN : NT;
      NT:      return t ? WN : TK;
      TK:      return t ? WT : NT;
      default: return t ? WT : TK;
    endcase
  endfunction

  always @(posedge clk) begin
    fsm_out_data <= fsm_next(fsm_in_data, fsm_torf);
    fsm_wr_en    <= !(fsm_torf && (fsm_in_data == WN || fsm_in_data == WT));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic v, input int idx, input logic l, input logic g);
    upd_valid     = v;
    upd_idx       = IDX_W'(idx);
    upd_local_ok  = l;
    upd_global_ok = g;
  endtask

  initial begin
    reset = 1'b1; pre_valid = 1'b0; pre_idx = '0;
    upd(1'b1, 4, 1'b1, 1'b0);
    cyc(); cyc();
    #1;
    check("rst_ready", upd_ready, 0);
    check("rst_sel_valid", pre_sel_valid, 0);
    check("rst_use_global", pre_use_global, 0);
    check("rst_fsm_in", fsm_in_data, INIT);
    check("rst_torf", fsm_torf, 0);

    // Lookups after reset
    reset = 1'b0; upd(1'b0, 0, 1'b0, 1'b0);
    pre_valid = 1'b1; pre_idx = 10'd5;
    cyc();
    check("lk5_valid", pre_sel_valid, 1);
    check("lk5_global", pre_use_global, 0);
    pre_idx = 10'd0;
    cyc();
    check("lk0_valid", pre_sel_valid, 1);
    check("lk0_global", pre_use_global, 0);
    pre_idx = 10'd1023;
    cyc();
    check("lk1023_valid", pre_sel_valid, 1);
    check("lk1023_global", pre_use_global, 0);
    pre_valid = 1'b0;
    cyc();
    check("lk_idle_valid", pre_sel_valid, 0);

    // Disagreeing update, idx 3: NTAKEN, local right -> WELL_NTAKEN
    upd(1'b1, 3, 1'b1, 1'b0);
    #1 check("u3_ready", upd_ready, 1);
    cyc();
    upd(1'b0, 3, 1'b1, 1'b0);
    check("u3_s1_data", fsm_in_data, NT);
    check("u3_s1_torf", fsm_torf, 1);
    cyc();
    check("u3_not_yet", dut.tbl_q[3], NT);
    check("u3_s1_empty", fsm_in_data, INIT);
    cyc();
    check("u3_commit", dut.tbl_q[3], WN);

    // Agreeing update, idx 7: consumed, no pipeline entry
    upd(1'b1, 7, 1'b1, 1'b1);
    #1 check("u7_ready", upd_ready, 1);
    cyc();
    upd(1'b0, 7, 1'b1, 1'b1);
    check("u7_no_s1", fsm_in_data, INIT);
    check("u7_no_torf", fsm_torf, 0);
    cyc(); cyc(); cyc();
    check("u7_unchanged", dut.tbl_q[7], INIT);
    check("u3_kept", dut.tbl_q[3], WN);

    // idx 9 setup: NTAKEN, local wrong -> TAKEN
    upd(1'b1, 9, 1'b0, 1'b1);
    cyc();
    upd(1'b0, 9, 1'b0, 1'b1);
    check("u9a_s1_data", fsm_in_data, NT);
    check("u9a_s1_torf", fsm_torf, 0);
    cyc(); cyc();
    check("u9a_commit", dut.tbl_q[9], TK);

    // Back-to-back idx 9: global wrong (TAKEN->NTAKEN), then local wrong (NTAKEN->TAKEN)
    upd(1'b1, 9, 1'b1, 1'b0);
    #1 check("u9b_ready", upd_ready, 1);
    cyc();
    upd(1'b1, 9, 1'b0, 1'b1);
    #1;
    check("u9c_stall", upd_ready, 0);
    check("u9b_s1_data", fsm_in_data, TK);
    check("u9b_s1_torf", fsm_torf, 0);
    cyc();
    #1;
    check("u9c_ready", upd_ready, 1);
    check("u9_bubble", fsm_in_data, INIT);
    cyc();
    upd(1'b0, 9, 1'b0, 1'b1);
    check("u9c_fwd_data", fsm_in_data, NT);
    check("u9c_s1_torf", fsm_torf, 0);
    check("u9b_commit", dut.tbl_q[9], NT);
    cyc(); cyc();
    check("u9c_commit", dut.tbl_q[9], TK);

    // idx 2, idx 11, idx 2: no stall, S2 forwarding, lookup write-first
    upd(1'b1, 2, 1'b0, 1'b1);
    cyc();
    upd(1'b1, 11, 1'b1, 1'b0);
    #1 check("u11_ready", upd_ready, 1);
    cyc();
    upd(1'b1, 2, 1'b1, 1'b0);
    pre_valid = 1'b1; pre_idx = 10'd2;
    #1 check("u2b_ready", upd_ready, 1);
    cyc();
    upd(1'b0, 2, 1'b1, 1'b0);
    pre_valid = 1'b0;
    check("u2b_fwd_data", fsm_in_data, TK);
    check("u2b_s1_torf", fsm_torf, 0);
    check("lk2_wf_valid", pre_sel_valid, 1);
    check("lk2_wf_global", pre_use_global, 1);
    cyc(); cyc();
    check("u2_final", dut.tbl_q[2], NT);
    check("u11_final", dut.tbl_q[11], WN);

    // Reset with S1 and S2 both occupied
    upd(1'b1, 20, 1'b0, 1'b1);
    cyc();
    upd(1'b1, 21, 1'b0, 1'b1);
    cyc();
    reset = 1'b1;
    upd(1'b1, 22, 1'b0, 1'b1);
    #1 check("mrst_ready", upd_ready, 0);
    cyc();
    reset = 1'b0;
    upd(1'b0, 22, 1'b0, 1'b1);
    check("mrst_s1_empty", fsm_in_data, INIT);
    check("mrst_torf", fsm_torf, 0);
    check("mrst_tbl20", dut.tbl_q[20], INIT);
    check("mrst_tbl9", dut.tbl_q[9], INIT);
    check("mrst_tbl3", dut.tbl_q[3], INIT);
    pre_valid = 1'b1; pre_idx = 10'd9;
    cyc();
    pre_idx = 10'd11;
    check("mrst_lk9_valid", pre_sel_valid, 1);
    check("mrst_lk9_global", pre_use_global, 0);
    cyc();
    pre_valid = 1'b0;
    check("mrst_lk11_global", pre_use_global, 0);
    check("mrst_tbl21", dut.tbl_q[21], INIT);
    check("mrst_tbl22", dut.tbl_q[22], INIT);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
